edge_event_capture: RTL and testbench
=====================================

# edge_event_capture

Parametrised, multi-mode successor to the 32-bit falling-edge sticky capture block. It samples a WIDTH-bit input bus and detects rising, falling or both edges per channel under per-channel enables. Detected edges latch into sticky status bits with per-bit write-1-to-clear, overflow flags, an arm/one-shot state machine and a saturating event counter. It sits between raw GPIO/status inputs and the interrupt/CSR layer.

## Interface
- WIDTH, 32: number of input channels (1..64)
- CNT_W, 8: width of event counter
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- data_i  in  WIDTH  input bus, sampled every cycle
- rise_en_i  in  WIDTH  per-channel rising-edge detect enable
- fall_en_i  in  WIDTH  per-channel falling-edge detect enable
- arm_i  in  1  pulse; IDLE -> ARMED
- oneshot_i  in  1  1: return to IDLE after first capture cycle
- clear_i  in  WIDTH  write-1-to-clear for edge_o and ovf_o bits
- cnt_clr_i  in  1  clear event counter
- edge_o  out  WIDTH  sticky captured-edge bits (registered)
- ovf_o  out  WIDTH  sticky overflow: edge seen while bit already set
- evt_cnt_o  out  CNT_W  saturating count of newly captured bits
- armed_o  out  1  FSM in ARMED
- irq_o  out  1  |edge_o (registered-derived, no extra delay)

## Operation
- Reset: data_q=0, prime_q=0, edge_o=0, ovf_o=0, evt_cnt_o=0, FSM=IDLE, armed_o=0, irq_o=0.
- Priming: first cycle after reset only loads data_q <= data_i and sets prime_q; no detection in that cycle.
- Per channel i, when prime_q=1: hit[i] = (rise_en_i[i] & data_i[i] & ~data_q[i]) | (fall_en_i[i] & ~data_i[i] & data_q[i]). Both enables set = any toggle.
- data_q updates every cycle regardless of FSM state.
- Capture only in ARMED; in IDLE hit is ignored (no edge, ovf or count update).
- new[i] = hit[i] & (~edge_q[i] | clear_i[i]); edge_q[i] next = new[i] | (edge_q[i] & ~clear_i[i]).
- ovf next = (hit[i] & edge_q[i] & ~clear_i[i]) | (ovf_q[i] & ~clear_i[i]).
- Counter: inc = popcount(new); next = (cnt_clr_i ? 0 : cnt) + inc, saturating at 2^CNT_W-1, never wraps.
- FSM IDLE: arm_i -> ARMED. ARMED: if oneshot_i and |new -> IDLE (that cycle's captures still latched); arm_i in ARMED ignored. Sticky bits persist across IDLE.
- Reset mid-operation clears all state and re-primes.

## Timing
- Edge on data_i at cycle N (vs sample N-1) -> edge_o/ovf_o/evt_cnt_o update at N+1; irq_o at N+1.
- clear_i at N -> bit low at N+1 unless same-cycle new hit (new hit wins, no ovf).
- arm_i at N -> armed_o=1 at N+1; hits at N+1 captured. Hit at cycle N with arm_i at N not captured.
- One-shot: capture cycle N -> armed_o=0 at N+1.

## Test plan
- Reset with data_i=all-ones, rise_en=all: priming cycle -> edge_o=0 after reset release; no spurious capture.
- ARMED, rise_en[3]=1, fall_en[5]=1; data_i bit3 0->1, bit5 1->0 at N -> edge_o=0x28 at N+1, evt_cnt_o=2, irq_o=1.
- Bit3 toggles again (rise) while set -> ovf_o[3]=1, evt_cnt unchanged; clear_i=0x8 -> edge_o[3]=ovf_o[3]=0 next cycle.
- clear_i[0] and new rise on bit0 same cycle -> edge_o[0]=1, ovf_o[0]=0, count +1.
- CNT_W=4, 20 bits rise in one cycle -> evt_cnt_o=15 (saturate); cnt_clr_i with 3 new bits -> 3.
- oneshot_i=1, arm, edge at N -> captured, armed_o=0 at N+1; later edges ignored until arm_i.

Source files
------------

// File: rtl/edge_event_capture.sv
// edge_event_capture: per-channel rising/falling edge detector with sticky
// capture bits, write-1-to-clear, overflow flags, arm/one-shot control and a
// saturating count of newly captured edges.
module edge_event_capture #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_i,
   input  logic [WIDTH-1:0] rise_en_i,
   input  logic [WIDTH-1:0] fall_en_i,
   input  logic             arm_i,
   input  logic             oneshot_i,
   input  logic [WIDTH-1:0] clear_i,
   input  logic             cnt_clr_i,
   output logic [WIDTH-1:0] edge_o,
   output logic [WIDTH-1:0] ovf_o,
   output logic [CNT_W-1:0] evt_cnt_o,
   output logic             armed_o,
   output logic             irq_o
);

   localparam int PC_W  = $clog2(WIDTH + 1);
   localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
   localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

   typedef enum logic [0:0] {IDLE, ARMED} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q;
   logic             prime_q;
   logic [WIDTH-1:0] edge_q, edge_d;
   logic [WIDTH-1:0] ovf_q, ovf_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hit, cap, new_hit;

   // Number of set bits in a channel vector.
   function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
      logic [PC_W-1:0] n;
      n = '0;
      for (int i = 0; i < WIDTH; i++) begin
         n = n + PC_W'(v[i]);
      end
      return n;
   endfunction

   // Add an increment to the counter, clamping at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [PC_W-1:0]  b);
      logic [SUM_W-1:0] s;
      s = SUM_W'(a) + SUM_W'(b);
      if (s > CNT_MAX) begin
         return '1;
      end
      return s[CNT_W-1:0];
   endfunction

   // Edge detection, sticky capture with W1C (a new hit beats a clear), overflow and count.
   always_comb begin
      hit     = '0;
      if (prime_q) begin
         hit = (rise_en_i & data_i & ~data_q) | (fall_en_i & ~data_i & data_q);
      end
      cap     = hit & {WIDTH{state_q == ARMED}};
      new_hit = cap & (~edge_q | clear_i);
      edge_d  = new_hit | (edge_q & ~clear_i);
      ovf_d   = (cap & edge_q & ~clear_i) | (ovf_q & ~clear_i);
      cnt_d   = sat_add(cnt_clr_i ? '0 : cnt_q, popcount(new_hit));
   end

   // Arm/one-shot next state: one-shot drops back to IDLE after the first capturing cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (arm_i) state_d = ARMED;
         ARMED:   if (oneshot_i && (|new_hit)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Input history, priming flag, sticky bits and counter; the first cycle after reset only primes.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q  <= '0;
         prime_q <= 1'b0;
         edge_q  <= '0;
         ovf_q   <= '0;
         cnt_q   <= '0;
      end else begin
         data_q  <= data_i;
         prime_q <= 1'b1;
         edge_q  <= edge_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   assign edge_o    = edge_q;
   assign ovf_o     = ovf_q;
   assign evt_cnt_o = cnt_q;
   assign armed_o   = (state_q == ARMED);
   assign irq_o     = |edge_q;

endmodule

// File: tb/tb_edge_event_capture.sv
// Directed scoreboard bench for edge_event_capture (WIDTH=32, CNT_W=4).
module tb_edge_event_capture;

   localparam int WIDTH = 32;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] data_i, rise_en_i, fall_en_i, clear_i;
   logic             arm_i, oneshot_i, cnt_clr_i;
   logic [WIDTH-1:0] edge_o, ovf_o;
   logic [CNT_W-1:0] evt_cnt_o;
   logic             armed_o, irq_o;

   typedef struct {
      string            name;
      int               tgt;
      logic [WIDTH-1:0] e_edge;
      logic [WIDTH-1:0] e_ovf;
      logic [CNT_W-1:0] e_cnt;
      logic             e_arm;
      logic             e_irq;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   edge_event_capture #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .data_i(data_i), .rise_en_i(rise_en_i),
      .fall_en_i(fall_en_i), .arm_i(arm_i), .oneshot_i(oneshot_i),
      .clear_i(clear_i), .cnt_clr_i(cnt_clr_i), .edge_o(edge_o), .ovf_o(ovf_o),
      .evt_cnt_o(evt_cnt_o), .armed_o(armed_o), .irq_o(irq_o)
   );

   always #5 clk = ~clk;

   // Cycle counter used to tag when each expectation becomes visible.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic cmp(input string nm, input string fld,
                      input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s.%s got=%h expected=%h", nm, fld, got, want);
      end
   endtask

   // Monitor: pop expectations as their cycle arrives and compare against the DUT.
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].tgt <= cyc) begin
         exp_t e;
         e = exp_q.pop_front();
         if (e.tgt < cyc) begin
            checks++;
            errors++;
            $display("FAIL %s.missed got=cycle %0d expected=cycle %0d", e.name, cyc, e.tgt);
         end else begin
            cmp(e.name, "edge",  edge_o, e.e_edge);
            cmp(e.name, "ovf",   ovf_o,  e.e_ovf);
            cmp(e.name, "cnt",   WIDTH'(evt_cnt_o), WIDTH'(e.e_cnt));
            cmp(e.name, "armed", WIDTH'(armed_o),   WIDTH'(e.e_arm));
            cmp(e.name, "irq",   WIDTH'(irq_o),     WIDTH'(e.e_irq));
         end
      end
   end

   // Apply the current inputs for one clock and queue the state expected after that edge.
   task automatic step(input string nm, input logic [WIDTH-1:0] e_edge,
                       input logic [WIDTH-1:0] e_ovf, input logic [CNT_W-1:0] e_cnt,
                       input logic e_arm, input logic e_irq);
      exp_t e;
      e.name = nm; e.tgt = cyc + 1; e.e_edge = e_edge; e.e_ovf = e_ovf;
      e.e_cnt = e_cnt; e.e_arm = e_arm; e.e_irq = e_irq;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; data_i = '1; rise_en_i = '1; fall_en_i = '0; clear_i = '0;
      arm_i = 1'b0; oneshot_i = 1'b0; cnt_clr_i = 1'b0;
      @(posedge clk); @(posedge clk); #1;

      reset = 1'b0;
      step("reset_prime", 32'h0, 32'h0, 4'd0, 1'b0, 1'b0);
      arm_i = 1'b1;
      step("arm", 32'h0, 32'h0, 4'd0, 1'b1, 1'b0);

      arm_i = 1'b0; rise_en_i = 32'h08; fall_en_i = 32'h20; data_i = 32'hFFFF_FFF7;
      step("fall_on_rise_ch", 32'h0, 32'h0, 4'd0, 1'b1, 1'b0);
      data_i = 32'hFFFF_FFDF;
      step("two_edges", 32'h28, 32'h0, 4'd2, 1'b1, 1'b1);
      arm_i = 1'b1; data_i = 32'hFFFF_FFD7;
      step("arm_in_armed", 32'h28, 32'h0, 4'd2, 1'b1, 1'b1);
      arm_i = 1'b0; data_i = 32'hFFFF_FFDF;
      step("ovf3", 32'h28, 32'h08, 4'd2, 1'b1, 1'b1);
      clear_i = 32'h08;
      step("clear3", 32'h20, 32'h0, 4'd2, 1'b1, 1'b1);

      clear_i = '0; rise_en_i = 32'h01; fall_en_i = '0; data_i = 32'hFFFF_FFDE;
      step("bit0_low", 32'h20, 32'h0, 4'd2, 1'b1, 1'b1);
      data_i = 32'hFFFF_FFDF;
      step("bit0_rise", 32'h21, 32'h0, 4'd3, 1'b1, 1'b1);
      data_i = 32'hFFFF_FFDE;
      step("bit0_fall", 32'h21, 32'h0, 4'd3, 1'b1, 1'b1);
      data_i = 32'hFFFF_FFDF; clear_i = 32'h01;
      step("clear_vs_new", 32'h21, 32'h0, 4'd4, 1'b1, 1'b1);

      clear_i = '0; rise_en_i = '0; data_i = 32'hF000_00DF;
      step("sat_setup", 32'h21, 32'h0, 4'd4, 1'b1, 1'b1);
      rise_en_i = 32'h0FFF_FF00; data_i = 32'hFFFF_FFDF;
      step("saturate", 32'h0FFF_FF21, 32'h0, 4'd15, 1'b1, 1'b1);
      rise_en_i = '0; data_i = 32'h8FFF_FFDF;
      step("clr_setup", 32'h0FFF_FF21, 32'h0, 4'd15, 1'b1, 1'b1);
      rise_en_i = 32'h7000_0000; data_i = 32'hFFFF_FFDF; cnt_clr_i = 1'b1;
      step("cnt_clr_plus3", 32'h7FFF_FF21, 32'h0, 4'd3, 1'b1, 1'b1);

      cnt_clr_i = 1'b0; rise_en_i = '0; oneshot_i = 1'b1; data_i = 32'h7FFF_FFDF;
      step("oneshot_wait", 32'h7FFF_FF21, 32'h0, 4'd3, 1'b1, 1'b1);
      rise_en_i = 32'h8000_0000; data_i = 32'hFFFF_FFDF;
      step("oneshot_cap", 32'hFFFF_FF21, 32'h0, 4'd4, 1'b0, 1'b1);
      clear_i = 32'h8000_0000; data_i = 32'h7FFF_FFDF;
      step("idle_clear", 32'h7FFF_FF21, 32'h0, 4'd4, 1'b0, 1'b1);
      clear_i = '0; data_i = 32'hFFFF_FFDF;
      step("idle_ignored", 32'h7FFF_FF21, 32'h0, 4'd4, 1'b0, 1'b1);
      arm_i = 1'b1; fall_en_i = 32'h8000_0000; data_i = 32'h7FFF_FFDF;
      step("arm_same_hit", 32'h7FFF_FF21, 32'h0, 4'd4, 1'b1, 1'b1);
      arm_i = 1'b0; data_i = 32'hFFFF_FFDF;
      step("rearm_cap", 32'hFFFF_FF21, 32'h0, 4'd5, 1'b0, 1'b1);

      reset = 1'b1;
      step("mid_reset", 32'h0, 32'h0, 4'd0, 1'b0, 1'b0);
      reset = 1'b0;

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #1;
      while (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         checks++;
         errors++;
         $display("FAIL %s.timeout got=pending expected=checked", e.name);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
